// File: rtl/quadrature_decoder.sv
// Quadrature decoder: two-flop sync, per-channel glitch filter, Gray-code decode to step/dir/count.
// QDEC_X4_EN defined: step on every legal transition; undefined: one step per full cycle (x1).
module qdec_chan #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic track,
  input  logic din,
  output logic s2,
  output logic filt
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic          s1;
  logic [CW-1:0] fcnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      fcnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      // Before tracking, filt simply trails s2 so the top can judge stability.
      if (!track) begin
        filt <= s2;
        fcnt <= '0;
      end else if (s2 != filt) begin
        if (fcnt == LAST) begin
          filt <= s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end
endmodule

module quadrature_decoder #(
  parameter int WIDTH    = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             err
);
  localparam int CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int STAGES = 2;
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);
`ifdef QDEC_X4_EN
  localparam logic X4 = 1'b1;
`else
  localparam logic X4 = 1'b0;
`endif

  typedef enum logic {INIT, TRACK} state_t;

  state_t        state, state_nxt;
  logic [1:0]    din, s2, filt, prev;
  logic [CW-1:0] icnt;
  logic [STAGES:0] vld_pipe;
  logic          tracking, stable, step_d, dir_d, err_d;

  assign din      = {enc_a, enc_b};
  assign tracking = (state == TRACK);
  // Sync flops hold their reset value, not a real sample, until the pipe has filled.
  assign stable   = vld_pipe[STAGES] && (s2 == filt);

  for (genvar i = 0; i < 2; i++) begin : g_chan
    qdec_chan #(.FILT_LEN(FILT_LEN)) u_chan (
      .clk   (clk),
      .reset (reset),
      .track (tracking),
      .din   (din[i]),
      .s2    (s2[i]),
      .filt  (filt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_d    = 1'b0;
    dir_d     = 1'b1;
    err_d     = 1'b0;
    case (state)
      INIT:  if (stable && icnt == LAST) state_nxt = TRACK;
      TRACK: begin
        case ({prev, filt})
          4'b00_10, 4'b10_11, 4'b11_01: begin step_d = X4;   dir_d = 1'b1; end
          4'b01_00:                     begin step_d = 1'b1; dir_d = 1'b1; end
          4'b00_01, 4'b01_11, 4'b11_10: begin step_d = X4;   dir_d = 1'b0; end
          4'b10_00:                     begin step_d = 1'b1; dir_d = 1'b0; end
          4'b00_11, 4'b11_00,
          4'b01_10, 4'b10_01:           err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      icnt     <= '0;
      prev     <= 2'b00;
      step     <= 1'b0;
      err      <= 1'b0;
      up_down  <= 1'b1;
      count    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      if (!tracking) begin
        prev <= s2;
        if (stable && icnt != LAST) icnt <= icnt + 1'b1;
        else                        icnt <= '0;
      end else begin
        prev <= filt;
        icnt <= '0;
      end
      step <= step_d;
      err  <= err_d;
      if (step_d) up_down <= dir_d;
      if (clear)       count <= '0;
      else if (step_d) count <= dir_d ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboarded random bench for quadrature_decoder; model tracks encoder phase as a Gray index mod 4.
module tb_quadrature_decoder;
  localparam int WIDTH    = 4;
  localparam int FILT_LEN = 3;
  localparam int LAT      = FILT_LEN + 2;
`ifdef QDEC_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  typedef struct {
    int               cyc;
    bit               err;
    bit               dir;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0, reset = 1'b0, enc_a = 1'b1, enc_b = 1'b1, clear = 1'b0;
  logic             step, up_down, err;
  logic [WIDTH-1:0] count;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               cyc = 0, npass = 0, ntot = 0;
  bit               mon_en = 1'b0;
  logic [1:0]       m_ph = 2'b11;
  logic [WIDTH-1:0] m_cnt = '0;
  bit               m_dir = 1'b1;
  bit               m_stepped = 1'b0;

  quadrature_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .clear   (clear),
    .step    (step),
    .up_down (up_down),
    .count   (count),
    .err     (err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Position along the up sequence 00->10->11->01.
  function automatic int idx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] up_next(input logic [1:0] p);
    case (idx(p))
      0:       return 2'b10;
      1:       return 2'b11;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new phase (called at a negedge) and hold it; optionally clear on the edge its step lands.
  task automatic move(input logic [1:0] ph, input int hold, input bit clr);
    int   e0, d;
    bit   stp, er;
    exp_t e;
    {enc_a, enc_b} = ph;
    e0  = cyc + 1;
    d   = (idx(ph) - idx(m_ph) + 4) % 4;
    stp = 1'b0;
    er  = (d == 2);
    if (d == 1 && (X4 || idx(ph) == 0)) begin stp = 1'b1; m_dir = 1'b1; m_cnt = m_cnt + 1'b1; end
    if (d == 3 && (X4 || idx(ph) == 0)) begin stp = 1'b1; m_dir = 1'b0; m_cnt = m_cnt - 1'b1; end
    if (clr && stp) m_cnt = '0;
    m_ph      = ph;
    m_stepped = stp;
    if (stp || er) begin
      e.cyc = e0 + LAT; e.err = er; e.dir = m_dir; e.cnt = m_cnt;
      exp_q.push_back(e);
    end
    for (int k = 0; k < hold; k++) begin
      clear = clr && stp && (cyc + 1 == e0 + LAT);
      @(negedge clk);
    end
    clear = 1'b0;
  endtask

  task automatic glitch(input int ch, input int len);
    logic [1:0] g;
    g     = m_ph;
    g[ch] = ~g[ch];
    {enc_a, enc_b} = g;
    repeat (len) @(negedge clk);
    {enc_a, enc_b} = m_ph;
    repeat (FILT_LEN + 3) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_cnt = '0;
    chk("clear_idle_count", int'(count), 0);
  endtask

  always @(negedge clk) if (mon_en) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      ntot++;
      $display("FAIL missed_event: expected at cycle %0d, still absent at cycle %0d", exp_q[0].cyc, cyc);
      mon_e = exp_q.pop_front();
    end
    if (step || err) begin
      if (exp_q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_output: step=%0b err=%0b count=%0d at cycle %0d", step, err, count, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("err", int'(err), int'(mon_e.err));
        chk("step", int'(step), int'(!mon_e.err));
        chk("up_down", int'(up_down), int'(mon_e.dir));
        chk("count", int'(count), int'(mon_e.cnt));
      end
    end
  end

  initial begin
    logic [1:0] np;
    int guard;
    @(negedge clk);
    enc_a = 1'b1; enc_b = 1'b1; reset = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_up_down", int'(up_down), 1);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset_count", int'(count), 0);

    // Walk to 00, then full up and down cycles.
    move(2'b01, FILT_LEN + 3, 1'b0);
    move(2'b00, FILT_LEN + 3, 1'b0);
    do_clear();
    move(2'b10, FILT_LEN + 3, 1'b0);
    move(2'b11, FILT_LEN + 3, 1'b0);
    move(2'b01, FILT_LEN + 3, 1'b0);
    move(2'b00, FILT_LEN + 3, 1'b0);
    chk("up_cycle_count", int'(count), int'(m_cnt));
    do_clear();
    move(2'b01, FILT_LEN + 3, 1'b0);
    move(2'b11, FILT_LEN + 3, 1'b0);
    move(2'b10, FILT_LEN + 3, 1'b0);
    move(2'b00, FILT_LEN + 3, 1'b0);
    chk("down_cycle_count", int'(count), int'(m_cnt));

    // Short bounce rejected; minimum-length pulse accepted.
    if (FILT_LEN > 1) glitch(1, FILT_LEN - 1);
    chk("glitch_count", int'(count), int'(m_cnt));
    move(2'b10, FILT_LEN, 1'b0);
    move(2'b00, FILT_LEN + 3, 1'b0);

    // Double transition flags err, then tracking continues.
    move(2'b11, FILT_LEN + 3, 1'b0);
    move(2'b01, FILT_LEN + 3, 1'b0);
    move(2'b00, FILT_LEN + 3, 1'b0);
    chk("after_err_count", int'(count), int'(m_cnt));

    repeat (60) begin
      if (FILT_LEN > 1 && $urandom_range(0, 3) == 0)
        glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, FILT_LEN - 1)));
      else
        move(2'($urandom_range(0, 3)), FILT_LEN + 3 + int'($urandom_range(0, 4)), 1'b0);
    end
    chk("random_walk_count", int'(count), int'(m_cnt));

    // Clear coinciding with an up step from 7.
    do_clear();
    guard = 0;
    while (m_cnt != 7 && guard < 64) begin
      move(up_next(m_ph), FILT_LEN + 3, 1'b0);
      guard++;
    end
    m_stepped = 1'b0;
    guard = 0;
    while (!m_stepped && guard < 8) begin
      move(up_next(m_ph), FILT_LEN + 3, 1'b1);
      guard++;
    end
    chk("clear_on_step_count", int'(count), 0);
    chk("clear_on_step_dir", int'(up_down), 1);

    // Reset in the middle of a transition.
    np = up_next(m_ph);
    {enc_a, enc_b} = np;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_count", int'(count), 0);
    chk("midrst_step", int'(step), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_up_down", int'(up_down), 1);
    reset = 1'b1;
    m_ph = np; m_cnt = '0; m_dir = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_midrst_count", int'(count), 0);
    move(up_next(m_ph), FILT_LEN + 3, 1'b0);
    move(up_next(m_ph), FILT_LEN + 3, 1'b0);
    chk("post_midrst_track_count", int'(count), int'(m_cnt));

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Converts a two-phase quadrature encoder signal pair (enc_a, enc_b) into single-cycle step pulses with a direction flag, plus a wrapping position count.
- It is the producer side of the step/direction interface that our up/down counters consume: step acts as the count enable, and up_down uses the same polarity (1 = up).
- Inputs are asynchronous and bouncy. The block synchronises them, filters glitches, decodes Gray-code transitions, and flags illegal double transitions.

Parameters:
WIDTH, 4, width of count.
FILT_LEN, 3, consecutive synchronised samples a new level must hold before acceptance (>=1; 1 = no filtering).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
enc_a  input  1  encoder phase A, asynchronous
enc_b  input  1  encoder phase B, asynchronous
clear  input  1  synchronous count clear, active-high
step  output  1  one-cycle pulse per decoded count event
up_down  output  1  direction of the last step (1 = up, 0 = down)
count  output  WIDTH  position, modulo 2^WIDTH
err  output  1  one-cycle pulse on an illegal transition

Behaviour:
- Reset: one clock, clk; reset is synchronous and active-low, sampled only on the rising edge of clk.
  - While reset = 0, the next edge forces: count = 0, step = 0, err = 0, up_down = 1, sync flops = 0, filter counters = 0, FSM = INIT.
  - Reset mid-operation discards all in-flight state; there is no partial step.
- Synchroniser: two flops per channel (s1, s2). Only s2 is used downstream.
- Filter, per channel:
  - fcnt increments each edge where s2 != filt.
  - When s2 != filt and fcnt == FILT_LEN-1, filt <= s2 and fcnt <= 0.
  - Any edge with s2 == filt clears fcnt, so a bounce restarts qualification.
- FSM:
  - INIT:
    - Waits until both channels have held s2 constant for FILT_LEN consecutive edges.
    - Then loads filt and prev from s2 and moves to TRACK.
    - No step or err is emitted in INIT, so any idle encoder state after reset is accepted silently.
  - TRACK:
    - Each edge compares prev = {A,B} with the current filt; prev <= filt.
    - Up sequence (A leads): 00->10->11->01->00.
    - Down sequence: 00->01->11->10->00.
    - Both bits changed (00<->11, 01<->10): err = 1 for one cycle, no step, count held, prev still updated.
    - No change: step = 0, err = 0.
- Outputs are registered.
  - step/up_down/count update on the same edge, one edge after filt changes.
  - Edge 0 = first rising edge sampling the new enc level. filt updates at edge FILT_LEN+1; step is high after edge FILT_LEN+2 for exactly one cycle.
- count:
  - Up step: +1. Down step: -1. Wraps at both ends (max+1 = 0, 0-1 = max).
  - up_down holds its last value when there is no step.
- clear:
  - Sets count = 0 on the next edge and overrides a simultaneous step's increment.
  - step/up_down/err still pulse normally.
  - clear is ignored while reset = 0.

Optional Feature:
- Macro: QDEC_X4_EN.
- Defined (x4 mode): every legal transition produces a step.
- Undefined (x1 mode):
  - Up step only on 01->00; down step only on 10->00.
  - Other legal transitions update prev silently.
  - err detection is identical in both modes.

Test Plan:
- Hold enc_a = enc_b = 1, reset low 3 cycles, then release; wait 10 cycles -> err never asserts, count = 0, step never asserts, FSM reaches TRACK.
- Up cycle 00->10->11->01->00, each state held 10 cycles -> x4: 4 step pulses with up_down = 1, count 0->4. x1: 1 pulse, count = 1. First pulse appears after edge FILT_LEN+2 (5 for default).
- From count = 0, down cycle 00->01->11->10->00 -> x4: count 0->F->E->D->C with up_down = 0. x1: count = F.
- From 00, enc_a high for 2 cycles then low (FILT_LEN = 3) -> no step, no err, count unchanged. enc_a high for 3 cycles -> filt accepts 10; x4: one up step.
- From 00, drive enc_a and enc_b high together -> err pulses exactly 1 cycle, no step, count unchanged; a following 11->01 gives an x4 up step (count +1).
- clear asserted on the same edge as an up step with count = 7 -> count = 0, step = 1, up_down = 1. Reset low during an active step sequence -> all outputs 0 (up_down = 1) next edge, FSM back to INIT.
